// File: rtl/div_iter_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: restoring division retiring STEP quotient bits per cycle,
// with a divide-by-zero/overflow fast path and a request/acknowledge writeback handshake.
module div_iter_unit #(
    parameter int               DATA        = 32,
    parameter int               STEP        = 1,
    parameter int               RD_W        = 5,
    parameter int               EXP_W       = 4,
    parameter bit               ZERO_EXP    = 1'b0,
    parameter logic [EXP_W-1:0] EXP_DIVZERO = EXP_W'(15)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_,
    input  logic             issue_,
    output logic             ready,
    input  logic [RD_W-1:0]  rd,
    input  logic [DATA-1:0]  data1,
    input  logic [DATA-1:0]  data2,
    input  logic [1:0]       command,
    output logic             wb_req_,
    output logic [RD_W-1:0]  pred_wb_rd,
    input  logic             wb_ack_,
    output logic             wb_e_,
    output logic [RD_W-1:0]  wb_rd,
    output logic [DATA-1:0]  wb_data,
    output logic             wb_exp_,
    output logic [EXP_W-1:0] wb_exp_code
);

    localparam int N     = DATA / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [DATA-1:0]  MIN  = {1'b1, {(DATA-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE,
        WB
    } state_t;

    state_t             state_q, state_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               remSel_q, remSel_d;
    logic               qNeg_q, qNeg_d;
    logic               rNeg_q, rNeg_d;
    logic               divZero_q, divZero_d;
    logic [DATA-1:0]    quo_q, quo_d;
    logic [DATA-1:0]    prem_q, prem_d;
    logic [DATA-1:0]    dvsr_q, dvsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA-1:0]    res_q, res_d;
    logic               wbE_q, wbE_d;
    logic [RD_W-1:0]    wbRd_q, wbRd_d;
    logic [DATA-1:0]    wbData_q, wbData_d;
    logic               wbExp_q, wbExp_d;
    logic [EXP_W-1:0]   wbCode_q, wbCode_d;

    logic               sign1, sign2;
    logic [DATA-1:0]    abs1, abs2;
    logic               isDivZero, isOverflow;
    logic [DATA-1:0]    stepQuo, stepRem;
    logic [DATA:0]      trial;
    logic [DATA-1:0]    quoFinal, remFinal;

    // Signedness only matters for DIV/REM (command[0]==0).
    assign sign1      = ~command[0] & data1[DATA-1];
    assign sign2      = ~command[0] & data2[DATA-1];
    assign abs1       = sign1 ? -data1 : data1;
    assign abs2       = sign2 ? -data2 : data2;
    assign isDivZero  = (data2 == '0);
    assign isOverflow = ~command[0] && (data1 == MIN) && (data2 == '1);

    // Dividend shifts out of quo MSB into the DATA+1 bit partial remainder; quotient bits enter at LSB.
    always_comb begin
        stepQuo = quo_q;
        stepRem = prem_q;
        trial   = '0;
        for (int i = 0; i < STEP; i++) begin
            trial   = {stepRem, stepQuo[DATA-1]};
            stepQuo = {stepQuo[DATA-2:0], 1'b0};
            if (trial >= {1'b0, dvsr_q}) begin
                stepRem    = trial[DATA-1:0] - dvsr_q;
                stepQuo[0] = 1'b1;
            end else begin
                stepRem = trial[DATA-1:0];
            end
        end
    end

    assign quoFinal = qNeg_q ? -stepQuo : stepQuo;
    assign remFinal = rNeg_q ? -stepRem : stepRem;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        remSel_d  = remSel_q;
        qNeg_d    = qNeg_q;
        rNeg_d    = rNeg_q;
        divZero_d = divZero_q;
        quo_d     = quo_q;
        prem_d    = prem_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        wbE_d     = 1'b1;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        wbExp_d   = 1'b1;
        wbCode_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (!issue_ && flush_) begin
                    rd_d      = rd;
                    remSel_d  = command[1];
                    qNeg_d    = sign1 ^ sign2;
                    rNeg_d    = sign1;
                    divZero_d = isDivZero;
                    quo_d     = abs1;
                    dvsr_d    = abs2;
                    prem_d    = '0;
                    cnt_d     = '0;
                    if (isDivZero) begin
                        res_d   = command[1] ? data1 : '1;
                        state_d = DONE;
                    end else if (isOverflow) begin
                        res_d   = command[1] ? '0 : MIN;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!flush_) begin
                    state_d = IDLE;
                end else begin
                    quo_d  = stepQuo;
                    prem_d = stepRem;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        res_d   = remSel_q ? remFinal : quoFinal;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Flush beats a same-cycle grant, so nothing is presented on the bus.
                if (!flush_) begin
                    state_d = IDLE;
                end else if (!wb_ack_) begin
                    state_d  = WB;
                    wbE_d    = 1'b0;
                    wbRd_d   = rd_q;
                    wbData_d = res_q;
                    if (ZERO_EXP && divZero_q) begin
                        wbExp_d  = 1'b0;
                        wbCode_d = EXP_DIVZERO;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            remSel_q  <= 1'b0;
            qNeg_q    <= 1'b0;
            rNeg_q    <= 1'b0;
            divZero_q <= 1'b0;
            quo_q     <= '0;
            prem_q    <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            wbE_q     <= 1'b1;
            wbRd_q    <= '0;
            wbData_q  <= '0;
            wbExp_q   <= 1'b1;
            wbCode_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            remSel_q  <= remSel_d;
            qNeg_q    <= qNeg_d;
            rNeg_q    <= rNeg_d;
            divZero_q <= divZero_d;
            quo_q     <= quo_d;
            prem_q    <= prem_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            wbE_q     <= wbE_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
            wbExp_q   <= wbExp_d;
            wbCode_q  <= wbCode_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign wb_req_     = (state_q != DONE);
    assign pred_wb_rd  = (state_q == DONE) ? rd_q : '0;
    assign wb_e_       = wbE_q;
    assign wb_rd       = wbRd_q;
    assign wb_data     = wbData_q;
    assign wb_exp_     = wbExp_q;
    assign wb_exp_code = wbCode_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: three instances (STEP=2, STEP=4 with div-zero exception, STEP=1)
// share stimulus; a vector table covers arithmetic and latency, hand sequences cover flush/reset/handshake.
module tb_div_iter_unit;

    localparam int NI = 3;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        bit          fast;
        bit          dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush_, issue_, wb_ack_;
    logic [4:0]  rd;
    logic [31:0] data1, data2;
    logic [1:0]  command;

    logic [NI-1:0] ready, wbReq, wbE, wbExp;
    logic [4:0]    predRd [NI];
    logic [4:0]    wbRd   [NI];
    logic [31:0]   wbData [NI];
    logic [3:0]    wbCode [NI];

    int nCalc [NI] = '{16, 8, 32};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    int rel = 0;
    int reqCyc [NI];
    int eCyc [NI];
    int readyCyc [NI];
    int eCount [NI];
    logic [31:0] capData [NI];
    logic [4:0]  capRd [NI];
    logic        capExp [NI];
    logic [3:0]  capCode [NI];

    vec_t vecs [19];

    div_iter_unit #(.DATA(32), .STEP(2), .RD_W(5), .EXP_W(4), .ZERO_EXP(1'b0), .EXP_DIVZERO(4'd15)) u0 (
        .clk(clk), .reset(reset), .flush_(flush_), .issue_(issue_), .ready(ready[0]),
        .rd(rd), .data1(data1), .data2(data2), .command(command),
        .wb_req_(wbReq[0]), .pred_wb_rd(predRd[0]), .wb_ack_(wb_ack_), .wb_e_(wbE[0]),
        .wb_rd(wbRd[0]), .wb_data(wbData[0]), .wb_exp_(wbExp[0]), .wb_exp_code(wbCode[0]));

    div_iter_unit #(.DATA(32), .STEP(4), .RD_W(5), .EXP_W(4), .ZERO_EXP(1'b1), .EXP_DIVZERO(4'd15)) u1 (
        .clk(clk), .reset(reset), .flush_(flush_), .issue_(issue_), .ready(ready[1]),
        .rd(rd), .data1(data1), .data2(data2), .command(command),
        .wb_req_(wbReq[1]), .pred_wb_rd(predRd[1]), .wb_ack_(wb_ack_), .wb_e_(wbE[1]),
        .wb_rd(wbRd[1]), .wb_data(wbData[1]), .wb_exp_(wbExp[1]), .wb_exp_code(wbCode[1]));

    div_iter_unit #(.DATA(32), .STEP(1), .RD_W(5), .EXP_W(4), .ZERO_EXP(1'b0), .EXP_DIVZERO(4'd15)) u2 (
        .clk(clk), .reset(reset), .flush_(flush_), .issue_(issue_), .ready(ready[2]),
        .rd(rd), .data1(data1), .data2(data2), .command(command),
        .wb_req_(wbReq[2]), .pred_wb_rd(predRd[2]), .wb_ack_(wb_ack_), .wb_e_(wbE[2]),
        .wb_rd(wbRd[2]), .wb_data(wbData[2]), .wb_exp_(wbExp[2]), .wb_exp_code(wbCode[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Advance to the next falling edge and record handshake events; rel = cycle number after issue.
    task automatic tick();
        @(negedge clk);
        rel = cyc - base + 1;
        for (int k = 0; k < NI; k++) begin
            if (!wbReq[k] && reqCyc[k] < 0) reqCyc[k] = rel;
            if (!wbE[k]) begin
                eCount[k]++;
                eCyc[k]    = rel;
                capData[k] = wbData[k];
                capRd[k]   = wbRd[k];
                capExp[k]  = wbExp[k];
                capCode[k] = wbCode[k];
            end
            if (ready[k] && eCount[k] > 0 && readyCyc[k] < 0) readyCyc[k] = rel;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] r);
        command = cmd;
        data1   = a;
        data2   = b;
        rd      = r;
        issue_  = 1'b0;
        @(posedge clk);
        #1;
        base   = cyc;
        issue_ = 1'b1;
        for (int k = 0; k < NI; k++) begin
            reqCyc[k]   = -1;
            eCyc[k]     = -1;
            readyCyc[k] = -1;
            eCount[k]   = 0;
        end
    endtask

    task automatic waitRel(input int c);
        int guard = 0;
        while (rel != c && guard < 200) begin
            tick();
            guard++;
        end
        if (rel != c) checkOutput($sformatf("waitRel%0d.timeout", c), 32'(rel), 32'(c));
    endtask

    task automatic waitAllDone(input string tag, input int bound);
        int n = 0;
        while (!(readyCyc[0] >= 0 && readyCyc[1] >= 0 && readyCyc[2] >= 0) && n < bound) begin
            tick();
            n++;
        end
        checkOutput({tag, ".done"}, {31'd0, readyCyc[0] >= 0 && readyCyc[1] >= 0 && readyCyc[2] >= 0}, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s.i%0d.ready", tag, k), {31'd0, ready[k]}, 32'd1);
            checkOutput($sformatf("%s.i%0d.wb_req_", tag, k), {31'd0, wbReq[k]}, 32'd1);
            checkOutput($sformatf("%s.i%0d.wb_e_", tag, k), {31'd0, wbE[k]}, 32'd1);
            checkOutput($sformatf("%s.i%0d.wb_exp_", tag, k), {31'd0, wbExp[k]}, 32'd1);
            checkOutput($sformatf("%s.i%0d.pred_wb_rd", tag, k), {27'd0, predRd[k]}, 32'd0);
            checkOutput($sformatf("%s.i%0d.wb_rd", tag, k), {27'd0, wbRd[k]}, 32'd0);
            checkOutput($sformatf("%s.i%0d.wb_data", tag, k), wbData[k], 32'd0);
            checkOutput($sformatf("%s.i%0d.wb_exp_code", tag, k), {28'd0, wbCode[k]}, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // DIV=00 DIVU=01 REM=10 REMU=11
        vecs[0]  = '{2'b00, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0, 1'b0};
        vecs[1]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   1'b0, 1'b0};
        vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          5'd5,  32'hFFFFFFFD,   1'b0, 1'b0};
        vecs[3]  = '{2'b01, 32'hFFFFFFFF,   32'd2,          5'd6,  32'h7FFFFFFF,   1'b0, 1'b0};
        vecs[4]  = '{2'b11, 32'hFFFFFFFF,   32'd2,          5'd7,  32'd1,          1'b0, 1'b0};
        vecs[5]  = '{2'b01, 32'd5,          32'd0,          5'd8,  32'hFFFFFFFF,   1'b1, 1'b1};
        vecs[6]  = '{2'b11, 32'd5,          32'd0,          5'd9,  32'd5,          1'b1, 1'b1};
        vecs[7]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000,   1'b1, 1'b0};
        vecs[8]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          1'b1, 1'b0};
        vecs[9]  = '{2'b10, 32'd100,        32'd7,          5'd12, 32'd2,          1'b0, 1'b0};
        vecs[10] = '{2'b00, 32'd7,          32'hFFFFFFFE,   5'd13, 32'hFFFFFFFD,   1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'd7,          32'hFFFFFFFE,   5'd14, 32'd1,          1'b0, 1'b0};
        vecs[12] = '{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'd15, 32'd14,         1'b0, 1'b0};
        vecs[13] = '{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'd16, 32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[14] = '{2'b00, 32'h80000000,   32'd2,          5'd17, 32'hC0000000,   1'b0, 1'b0};
        vecs[15] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   5'd18, 32'h80000000,   1'b0, 1'b0};
        vecs[16] = '{2'b01, 32'hDEADBEEF,   32'h00001234,   5'd19, 32'h000C3BA5,   1'b0, 1'b0};
        vecs[17] = '{2'b11, 32'hDEADBEEF,   32'h00001234,   5'd20, 32'h0000076B,   1'b0, 1'b0};
        vecs[18] = '{2'b10, 32'hFFFFFFF9,   32'd0,          5'd21, 32'hFFFFFFF9,   1'b1, 1'b1};

        reset   = 1'b1;
        flush_  = 1'b1;
        issue_  = 1'b1;
        wb_ack_ = 1'b1;
        rd      = '0;
        data1   = '0;
        data2   = '0;
        command = '0;
        for (int k = 0; k < NI; k++) begin
            reqCyc[k] = -1; eCyc[k] = -1; readyCyc[k] = -1; eCount[k] = 0;
        end
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        // Table: grant held low so each instance writes back the cycle after it requests.
        wb_ack_ = 1'b0;
        for (int v = 0; v < 19; v++) begin
            applyStimulus(vecs[v].cmd, vecs[v].a, vecs[v].b, vecs[v].rd);
            waitAllDone($sformatf("v%0d", v), 60);
            for (int k = 0; k < NI; k++) begin
                int expReq;
                bit raise;
                expReq = vecs[v].fast ? 1 : nCalc[k] + 1;
                raise  = vecs[v].dz && (k == 1);
                checkOutput($sformatf("v%0d.i%0d.reqCycle", v, k), 32'(reqCyc[k]), 32'(expReq));
                checkOutput($sformatf("v%0d.i%0d.wbCycle", v, k), 32'(eCyc[k]), 32'(expReq + 1));
                checkOutput($sformatf("v%0d.i%0d.readyCycle", v, k), 32'(readyCyc[k]), 32'(expReq + 2));
                checkOutput($sformatf("v%0d.i%0d.wbCount", v, k), 32'(eCount[k]), 32'd1);
                checkOutput($sformatf("v%0d.i%0d.data", v, k), capData[k], vecs[v].res);
                checkOutput($sformatf("v%0d.i%0d.rd", v, k), {27'd0, capRd[k]}, {27'd0, vecs[v].rd});
                checkOutput($sformatf("v%0d.i%0d.exp_", v, k), {31'd0, capExp[k]}, {31'd0, !raise});
                checkOutput($sformatf("v%0d.i%0d.expCode", v, k), {28'd0, capCode[k]}, raise ? 32'd15 : 32'd0);
            end
        end

        // A: delayed grant on the STEP=2 instance, request must hold until acknowledged.
        wb_ack_ = 1'b1;
        applyStimulus(2'b00, 32'd100, 32'd7, 5'd9);
        waitRel(16);
        checkOutput("A.req16", {31'd0, wbReq[0]}, 32'd1);
        waitRel(17);
        checkOutput("A.req17", {31'd0, wbReq[0]}, 32'd0);
        checkOutput("A.pred17", {27'd0, predRd[0]}, 32'd9);
        waitRel(20);
        checkOutput("A.req20", {31'd0, wbReq[0]}, 32'd0);
        checkOutput("A.pred20", {27'd0, predRd[0]}, 32'd9);
        checkOutput("A.wbE20", {31'd0, wbE[0]}, 32'd1);
        checkOutput("A.ready20", {31'd0, ready[0]}, 32'd0);
        wb_ack_ = 1'b0;
        tick();
        wb_ack_ = 1'b1;
        checkOutput("A.wbE21", {31'd0, wbE[0]}, 32'd0);
        checkOutput("A.data21", wbData[0], 32'd14);
        checkOutput("A.rd21", {27'd0, wbRd[0]}, 32'd9);
        checkOutput("A.ready21", {31'd0, ready[0]}, 32'd0);
        tick();
        checkOutput("A.ready22", {31'd0, ready[0]}, 32'd1);
        checkOutput("A.wbE22", {31'd0, wbE[0]}, 32'd1);
        checkOutput("A.wbCount", 32'(eCount[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // B: flush in CALC cycle 8, then a new issue in cycle 9.
        applyStimulus(2'b01, 32'd1000, 32'd3, 5'd11);
        waitRel(8);
        flush_ = 1'b0;
        tick();
        flush_ = 1'b1;
        checkOutput("B.ready9", {31'd0, ready[0]}, 32'd1);
        checkOutput("B.ready9.i1", {31'd0, ready[1]}, 32'd1);
        checkOutput("B.noReq", {31'd0, reqCyc[0] < 0 && reqCyc[1] < 0}, 32'd1);
        checkOutput("B.noWb", 32'(eCount[0] + eCount[1] + eCount[2]), 32'd0);
        wb_ack_ = 1'b0;
        applyStimulus(2'b10, 32'd100, 32'd7, 5'd12);
        waitAllDone("B", 60);
        checkOutput("B.reqCycle", 32'(reqCyc[0]), 32'd17);
        checkOutput("B.data", capData[0], 32'd2);
        checkOutput("B.rd", {27'd0, capRd[0]}, 32'd12);

        // C: flush and grant in the same DONE cycle -> no writeback at all.
        wb_ack_ = 1'b1;
        applyStimulus(2'b01, 32'd5, 32'd0, 5'd13);
        tick();
        checkOutput("C.req1", {31'd0, wbReq[0]}, 32'd0);
        wb_ack_ = 1'b0;
        flush_  = 1'b0;
        tick();
        wb_ack_ = 1'b1;
        flush_  = 1'b1;
        checkOutput("C.ready2", {31'd0, ready[0]}, 32'd1);
        checkOutput("C.req2", {31'd0, wbReq[0]}, 32'd1);
        repeat (3) tick();
        checkOutput("C.noWb.i0", 32'(eCount[0]), 32'd0);
        checkOutput("C.noWb.i1", 32'(eCount[1]), 32'd0);

        // D: issue while busy is ignored.
        applyStimulus(2'b00, 32'd100, 32'd7, 5'd4);
        waitRel(5);
        command = 2'b10;
        data1   = 32'd50;
        data2   = 32'd5;
        rd      = 5'd7;
        issue_  = 1'b0;
        tick();
        issue_  = 1'b1;
        checkOutput("D.busy", {31'd0, ready[0]}, 32'd0);
        wb_ack_ = 1'b0;
        waitAllDone("D", 60);
        checkOutput("D.reqCycle", 32'(reqCyc[0]), 32'd17);
        checkOutput("D.data", capData[0], 32'd14);
        checkOutput("D.rd", {27'd0, capRd[0]}, 32'd4);
        checkOutput("D.wbCount", 32'(eCount[0]), 32'd1);
        repeat (3) tick();
        checkOutput("D.wbCountAfter", 32'(eCount[0]), 32'd1);

        // E: reset mid-CALC discards the operation and clears held writeback values.
        applyStimulus(2'b01, 32'hDEADBEEF, 32'h00001234, 5'd21);
        waitRel(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetValues("E");
        repeat (40) tick();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("E.i%0d.noWb", k), 32'(eCount[k]), 32'd0);
            checkOutput($sformatf("E.i%0d.noReq", k), {31'd0, reqCyc[k] < 0}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised iterative integer divide/remainder unit for the execute stage: accepts one DIV/DIVU/REM/REMU operation per issue, retires STEP quotient bits per cycle, then arbitrates for the writeback bus with a request/acknowledge handshake. It supersedes the fixed-latency divider wrapper and adds configurable radix, a divide-by-zero/overflow fast path, selectable divide-by-zero exception mode, and flush abort at any stage. It sits beside the ALU/multiplier behind the issue queue and shares the writeback arbiter.

## Interface
- DATA, 32, operand/result width
- STEP, 1, quotient bits per cycle; legal values 1, 2, 4; must divide DATA
- RD_W, 5, destination register index width
- EXP_W, 4, exception code width
- ZERO_EXP, 0, 1 = divide by zero raises exception; 0 = architectural result, no exception
- EXP_DIVZERO, 4'd15, exception code reported on divide by zero when ZERO_EXP=1

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush_  in  1  active-low; abort in-flight operation
- issue_  in  1  active-low; issue request, accepted only when ready=1
- ready  out  1  unit idle, can accept issue
- rd  in  RD_W  destination register
- data1  in  DATA  dividend
- data2  in  DATA  divisor
- command  in  2  bit0 = unsigned, bit1 = remainder
- wb_req_  out  1  active-low writeback request
- pred_wb_rd  out  RD_W  destination of pending request
- wb_ack_  in  1  active-low grant from arbiter
- wb_e_  out  1  active-low writeback valid
- wb_rd  out  RD_W  writeback destination
- wb_data  out  DATA  result
- wb_exp_  out  1  active-low exception flag
- wb_exp_code  out  EXP_W  exception code

## Operation
- States: IDLE, CALC, DONE, WB. ready=1 only in IDLE.
- IDLE: issue_=0 and flush_=1 -> latch rd, command, |data1|, |data2| (abs only for signed), quotient sign = sign1^sign2, remainder sign = sign1; clear counter; -> CALC. issue_ while not IDLE is ignored.
- Fast path at issue: data2==0 -> result quotient all ones / remainder data1, -> DONE directly. Signed with data1=MIN and data2=-1 -> quotient MIN, remainder 0, -> DONE directly.
- CALC: restoring division, STEP bits per cycle, counter 0..DATA/STEP-1; on last count apply sign correction, select quotient/remainder per command, register result, -> DONE.
- DONE: wb_req_=0, pred_wb_rd=rd. wb_ack_=0 -> WB.
- WB (one cycle): wb_e_=0, wb_rd, wb_data, wb_exp_, wb_exp_code valid; -> IDLE.
- Divide by zero with ZERO_EXP=1: wb_exp_=0, wb_exp_code=EXP_DIVZERO, wb_data=result as above; otherwise wb_exp_=1, wb_exp_code=0.
- flush_=0 in IDLE/CALC/DONE -> IDLE next cycle, no wb_req_/wb_e_; wins over simultaneous wb_ack_ or issue_. flush_ in WB: writeback already presented completes, -> IDLE.
- All arithmetic modulo 2^DATA; internal partial remainder DATA+1 bits.

## Timing
- Reset values: ready=1 (state IDLE), wb_req_=1, wb_e_=1, wb_exp_=1, pred_wb_rd=0, wb_rd=0, wb_data=0, wb_exp_code=0. Reset mid-operation discards it.
- Issue accepted at edge 0; CALC cycles 1..N, N=DATA/STEP; wb_req_ low from cycle N+1. Fast path: wb_req_ low in cycle 1.
- Ack sampled low in cycle k -> wb_e_ low exactly in cycle k+1, ready in cycle k+2. Minimum issue-to-issue: N+3 cycles.
- wb_req_ and pred_wb_rd stable until ack or flush; wb_e_ never low for more than one cycle per operation.
- wb_* outputs registered; ready, wb_req_, pred_wb_rd decode state only.

## Test plan
- DATA=32, STEP=2: DIV 100/7 issued cycle 0 -> wb_req_ low cycle 17; ack cycle 20 -> wb_e_ low cycle 21, wb_data=14, wb_rd=rd, ready cycle 22.
- REM -7 % 2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF%2 -> 1; repeat with STEP=1 (wb_req_ cycle 33) and STEP=4 (cycle 9).
- DIVU 5/0, ZERO_EXP=0 -> wb_req_ cycle 1, data 0xFFFFFFFF, wb_exp_=1; REMU 5/0 -> 5; ZERO_EXP=1 -> wb_exp_=0, code 15.
- DIV 0x80000000/-1 -> 0x80000000, REM -> 0, wb_req_ cycle 1.
- flush_ low cycle 8 of CALC -> no wb_req_, ready cycle 9, new issue accepted; flush_ and wb_ack_ low same DONE cycle -> no wb_e_; issue_ while busy -> ignored, result unchanged.
- reset high mid-CALC -> all outputs at reset values next cycle, no writeback.
